// File: rtl/id_fsm_pkg.sv
// Shared types and ASCII bounds for the identifier recognizer.
// ID_UNDERSCORE_EN (optional) makes '_' count as a letter.
package id_fsm_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ALPHA = 2'b01,
      S_ID    = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      CLS_OTHER  = 2'b00,
      CLS_LETTER = 2'b01,
      CLS_DIGIT  = 2'b10
   } cls_t;

   localparam logic [7:0] ASCII_0  = 8'd48;
   localparam logic [7:0] ASCII_9  = 8'd57;
   localparam logic [7:0] ASCII_A  = 8'd65;
   localparam logic [7:0] ASCII_Z  = 8'd90;
   localparam logic [7:0] ASCII_LA = 8'd97;
   localparam logic [7:0] ASCII_LZ = 8'd122;
   localparam logic [7:0] ASCII_US = 8'd95;

   function automatic logic in_range(
      input logic [7:0] c,
      input logic [7:0] lo,
      input logic [7:0] hi
   );
      return (c >= lo) && (c <= hi);
   endfunction

endpackage

// File: rtl/id_fsm_core_classifier.sv
// Maps one ASCII byte to LETTER / DIGIT / OTHER.
// ID_UNDERSCORE_EN (optional) classifies '_' as LETTER.
import id_fsm_pkg::*;

module id_char_classifier (
   input  logic [7:0] char_i,
   output cls_t       cls_o
);

   logic is_alpha;
   logic is_us;
   logic is_letter;
   logic is_digit;

   assign is_alpha = in_range(char_i, ASCII_A, ASCII_Z)
                   | in_range(char_i, ASCII_LA, ASCII_LZ);

`ifdef ID_UNDERSCORE_EN
   assign is_us = (char_i == ASCII_US);
`else
   assign is_us = 1'b0;
`endif

   assign is_letter = is_alpha | is_us;
   assign is_digit  = in_range(char_i, ASCII_0, ASCII_9);

   // letter and digit ranges are disjoint, so at most one arm fires
   always_comb begin
      cls_o = CLS_OTHER;
      unique case (1'b1)
         is_letter: cls_o = CLS_LETTER;
         is_digit:  cls_o = CLS_DIGIT;
         default:   cls_o = CLS_OTHER;
      endcase
   end

endmodule

// File: rtl/id_fsm_core.sv
// Streaming letter+ digit+ recognizer, Moore output.
// ID_UNDERSCORE_EN (optional) is handled in the classifier.
import id_fsm_pkg::*;

module id_fsm_core (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] char,
   output logic       out
);

   cls_t   cls;
   state_t state_q = S_IDLE;
   state_t state_d;

   id_char_classifier u_cls (
      .char_i (char),
      .cls_o  (cls)
   );

   // state register, reset wins over the incoming character
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state; the unused encoding falls back to idle
   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE: begin
            if (cls == CLS_LETTER) state_d = S_ALPHA;
            else                   state_d = S_IDLE;
         end
         S_ALPHA: begin
            if (cls == CLS_LETTER)     state_d = S_ALPHA;
            else if (cls == CLS_DIGIT) state_d = S_ID;
            else                       state_d = S_IDLE;
         end
         S_ID: begin
            if (cls == CLS_LETTER)     state_d = S_ALPHA;
            else if (cls == CLS_DIGIT) state_d = S_ID;
            else                       state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // output decodes the registered state only
   always_comb begin
      out = 1'b0;
      if (state_q == S_ID) out = 1'b1;
   end

endmodule

// File: tb/tb_id_fsm_core.sv
// Bench for id_fsm_core: directed tables plus random stream vs model.
// Define ID_UNDERSCORE_EN here too when building the variant.
module tb_id_fsm_core;

   logic       clk;
   logic       rst;
   logic [7:0] ch;
   logic       dut_out;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] hist[$];

   id_fsm_core dut (
      .clk   (clk),
      .reset (rst),
      .char  (ch),
      .out   (dut_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit m_letter(input logic [7:0] c);
`ifdef ID_UNDERSCORE_EN
      if (c == 8'd95) return 1'b1;
`endif
      return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
   endfunction

   function automatic bit m_digit(input logic [7:0] c);
      return c >= "0" && c <= "9";
   endfunction

   // history since reset ends in: letter, then one or more digits
   function automatic logic model_out();
      int i;
      i = hist.size() - 1;
      if (i < 0) return 1'b0;
      if (!m_digit(hist[i])) return 1'b0;
      while (i >= 0 && m_digit(hist[i])) i--;
      return (i >= 0) && m_letter(hist[i]);
   endfunction

   task automatic drive(input logic [7:0] c, input logic r);
      ch  = c;
      rst = r;
      @(posedge clk);
      #1;
      if (r) hist.delete();
      else   hist.push_back(c);
      n_vec++;
   endtask

   task automatic test_reset();
      drive(8'd45, 1'b1);
      if (dut_out !== 1'b0) begin
         n_err++;
         $display("FAIL reset: out=%b want 0", dut_out);
      end
      drive(8'd45, 1'b0);
      if (dut_out !== 1'b0) begin
         n_err++;
         $display("FAIL reset_dash: out=%b want 0", dut_out);
      end
   endtask

   task automatic test_basic_run();
      logic [7:0] cs[9] = '{"a", "b", "c", "d", "1", "2", "3", "4", 8'hFD};
      logic       ex[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      for (int i = 0; i < 9; i++) begin
         drive(cs[i], 1'b0);
         if (dut_out !== ex[i]) begin
            n_err++;
            $display("FAIL basic[%0d] ch=%h: out=%b want %b",
                     i, cs[i], dut_out, ex[i]);
         end
      end
   endtask

   task automatic test_restart();
      logic [7:0] cs[5] = '{"-", "a", "1", "b", "2"};
      logic       ex[5] = '{0, 0, 1, 0, 1};
      for (int i = 0; i < 5; i++) begin
         drive(cs[i], 1'b0);
         if (dut_out !== ex[i]) begin
            n_err++;
            $display("FAIL restart[%0d] ch=%h: out=%b want %b",
                     i, cs[i], dut_out, ex[i]);
         end
      end
   endtask

   task automatic test_leading_digits();
      logic [7:0] cs[5] = '{"-", "1", "2", "a", "3"};
      logic       ex[5] = '{0, 0, 0, 0, 1};
      for (int i = 0; i < 5; i++) begin
         drive(cs[i], 1'b0);
         if (dut_out !== ex[i]) begin
            n_err++;
            $display("FAIL lead[%0d] ch=%h: out=%b want %b",
                     i, cs[i], dut_out, ex[i]);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] cs[6] = '{"-", "a", "b", "1", "2", "3"};
      logic       rs[6] = '{0, 0, 0, 0, 1, 0};
      logic       ex[6] = '{0, 0, 0, 1, 0, 0};
      for (int i = 0; i < 6; i++) begin
         drive(cs[i], rs[i]);
         if (dut_out !== ex[i]) begin
            n_err++;
            $display("FAIL midreset[%0d] ch=%h rst=%b: out=%b want %b",
                     i, cs[i], rs[i], dut_out, ex[i]);
         end
      end
   endtask

   task automatic test_underscore();
`ifdef ID_UNDERSCORE_EN
      logic       ex[6] = '{0, 0, 1, 0, 0, 1};
`else
      logic       ex[6] = '{0, 0, 0, 0, 0, 0};
`endif
      logic [7:0] cs[6] = '{"-", "_", "1", "a", "_", "1"};
      for (int i = 0; i < 6; i++) begin
         drive(cs[i], 1'b0);
         if (dut_out !== ex[i]) begin
            n_err++;
            $display("FAIL underscore[%0d] ch=%h: out=%b want %b",
                     i, cs[i], dut_out, ex[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] c;
      logic       r;
      logic       exp;
      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 5))
            0: c = 8'("a" + $urandom_range(0, 25));
            1: c = 8'("A" + $urandom_range(0, 25));
            2, 3: c = 8'("0" + $urandom_range(0, 9));
            4: c = 8'd95;
            default: c = 8'($urandom_range(0, 255));
         endcase
         r = ($urandom_range(0, 39) == 0);
         drive(c, r);
         exp = model_out();
         if (dut_out !== exp) begin
            n_err++;
            $display("FAIL random[%0d] ch=%h rst=%b: out=%b want %b",
                     i, c, r, dut_out, exp);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      ch  = 8'd0;
      test_reset();
      test_basic_run();
      test_restart();
      test_leading_digits();
      test_reset_mid_run();
      test_underscore();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
